// File: rtl/unified_mem_arbiter.sv
// Purpose: shares one variable-latency memory between the fetch port and the data port; data wins, a streak limit protects fetch.
// Latency: req in cycle 0, mem_req in cycle 1, done pulse one cycle after mem_ack (2 cycles minimum).
// Backpressure: requesters hold req until their done pulse; mem_req is held stable until mem_ack; stall_* freeze the pipeline meanwhile.
module unified_mem_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_data,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_done,
    output logic [DW-1:0] dm_rdata,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] streak;
    logic       if_elig;
    logic       dm_elig;
    logic       grant_i;
    logic       grant_d;
    logic       ack_i;
    logic       ack_d;

    // A requester whose done pulse is showing still has its stale req high; it must not be granted again.
    assign if_elig = if_req & ~if_done;
    assign dm_elig = dm_req & ~dm_done;

    // Completion is only meaningful while a grant is outstanding; a stray ack in IDLE falls through.
    assign ack_i = (state == GNT_I) & mem_ack;
    assign ack_d = (state == GNT_D) & mem_ack;

    assign stall_if  = if_req & ~if_done;
    assign stall_mem = dm_req & ~dm_done;
    assign busy      = (state != IDLE);

    // Arbitration and next-state: data first unless fetch has been passed over STARVE_LIMIT times.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (if_elig && dm_elig) begin
                    if (streak == LIMIT) grant_i = 1'b1;
                    else                 grant_d = 1'b1;
                end else if (if_elig) begin
                    grant_i = 1'b1;
                end else if (dm_elig) begin
                    grant_d = 1'b1;
                end
                if (grant_i)      state_nxt = GNT_I;
                else if (grant_d) state_nxt = GNT_D;
            end
            GNT_I, GNT_D: begin
                if (mem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Streak of data grants taken while a fetch was pending; saturates at the limit, cleared by any fetch grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= 4'd0;
        end else if (grant_i) begin
            streak <= 4'd0;
        end else if (grant_d && if_req && (streak != LIMIT)) begin
            streak <= streak + 4'd1;
        end
    end

    // Memory-side request registers: captured on grant and held untouched until the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_i) begin
            // A fetch carries no write data; mem_wdata is left as is since mem_we=0 makes it irrelevant.
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
        end else if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
        end else if (ack_i || ack_d) begin
            mem_req <= 1'b0;
        end
    end

    // Done pulses and returned data, registered one cycle after the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_done  <= 1'b0;
            dm_done  <= 1'b0;
            if_data  <= '0;
            dm_rdata <= '0;
        end else begin
            if_done <= ack_i;
            dm_done <= ack_d;
            if (ack_i)            if_data  <= mem_rdata;
            if (ack_d && !mem_we) dm_rdata <= mem_rdata;
        end
    end

endmodule
